seq_stage_ctrl: RTL and testbench
=================================

SEQ_STAGE_CTRL -- requirements
Module: seq_stage_ctrl

Interface
REQ-001 Parameter RESET_PC, default 64'd0: PC value loaded on reset.
REQ-002 clk  in  1  system clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset; asynchronous assert, active-low.
REQ-004 run  in  1  level; 1 = free-run instructions back-to-back.
REQ-005 step  in  1  one-cycle pulse; in IDLE, starts exactly one instruction.
REQ-006 icode  in  4  from fetch; valid during FETCH.
REQ-007 imem_error, invalid_instr  in  1 each  from fetch; valid during FETCH.
REQ-008 dmem_error  in  1  from memory stage; valid during MEMORY.
REQ-009 cnd  in  1  condition result from execute; valid during EXECUTE.
REQ-010 valC, valP, valM  in  64 each  next-PC candidates; valid at end of MEMORY.
REQ-011 PC  out  64  current instruction address to fetch.
REQ-012 en_f, en_d, en_e, en_m, en_w  out  1 each  stage enables; at most one high per cycle.
REQ-013 stat  out  3  AOK=1, HLT=2, ADR=3, INS=4.
REQ-014 busy  out  1  high in any state except IDLE and HALTED.
REQ-015 instr_count  out  32  retired-instruction counter.

Function
REQ-016 States: IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALTED; encoding one-hot or binary, implementer's choice.
REQ-017 IDLE -> FETCH when run=1 or step=1; otherwise stay.
REQ-018 FETCH -> DECODE -> EXECUTE -> MEMORY -> WRITEBACK -> PCUPD, one cycle each; normal latency 6 cycles per instruction.
REQ-019 PCUPD -> FETCH if run=1, else IDLE.
REQ-020 Stage enable is high exactly in its state: en_f in FETCH, en_d in DECODE, en_e in EXECUTE, en_m in MEMORY, en_w in WRITEBACK; all low elsewhere.
REQ-021 cnd registered at end of EXECUTE; later changes ignored.
REQ-022 PC loaded at end of PCUPD: icode 8 (call) -> valC; icode 9 (ret) -> valM; icode 7 (jXX) -> valC if latched cnd=1, else valP; all other icodes -> valP.
REQ-023 icode registered at end of FETCH; registered value drives REQ-022.
REQ-024 instr_count increments by 1 at end of PCUPD; wraps 32'hFFFFFFFF -> 0.
REQ-025 Fetch exception priority at end of FETCH: imem_error (stat=ADR) > invalid_instr (stat=INS) > icode 0 (stat=HLT); any of these -> HALTED.
REQ-026 dmem_error at end of MEMORY -> stat=ADR, HALTED; en_w never asserted for that instruction.
REQ-027 On any HALTED entry, PC and instr_count do not change.
REQ-028 HALTED is terminal; only rst_n leaves it; run and step ignored.
REQ-029 step asserted outside IDLE is ignored, not queued.
REQ-030 run deasserted mid-instruction: current instruction completes, then IDLE.

Reset
REQ-031 rst_n=0 immediately forces: state IDLE, PC=RESET_PC, stat=AOK, instr_count=0, all enables 0, busy 0, latched icode/cnd 0.
REQ-032 Reset mid-instruction aborts it with no PC or count update; first FETCH after release requires run or step.

Structure
REQ-033 Shared package y86_pkg holds icode constants (HALT..POPQ), stat codes, and the state enumeration.
REQ-034 One sub-module, seq_next_pc: combinational next-PC selection per REQ-022, reusable by the pipelined design.

Verification
REQ-035 run=1, icodes 1 (nop) then 3 (irmovq), valP=2 then 12 -> six-cycle stage sequence each; PC 0->2->12; instr_count=2.
REQ-036 icode 7, cnd=1, valC=0x40 -> PC=0x40; repeat with cnd=0, valP=0x09 -> PC=0x09.
REQ-037 icode 8, valC=0x100, then icode 9, valM=0x13 -> PC=0x100 then 0x13.
REQ-038 FETCH with imem_error=1 and invalid_instr=1 -> stat=ADR, HALTED, no en_d; PC unchanged; later step ignored.
REQ-039 run=0, one step pulse -> exactly one instruction, then IDLE, busy=0; dmem_error during MEMORY -> stat=ADR, en_w never high.
REQ-040 rst_n low in EXECUTE -> same cycle: enables 0, PC=RESET_PC, instr_count=0, stat=AOK.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: widths, instruction codes, status codes and the
// sequential controller state enumeration.
package y86_pkg;

    localparam int unsigned ADDR_W  = 64;
    localparam int unsigned ICODE_W = 4;
    localparam int unsigned STAT_W  = 3;
    localparam int unsigned COUNT_W = 32;
    localparam int unsigned STAGE_N = 5;

    localparam logic [ICODE_W-1:0] ICODE_HALT   = 4'h0;
    localparam logic [ICODE_W-1:0] ICODE_NOP    = 4'h1;
    localparam logic [ICODE_W-1:0] ICODE_RRMOVQ = 4'h2;
    localparam logic [ICODE_W-1:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [ICODE_W-1:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [ICODE_W-1:0] ICODE_MRMOVQ = 4'h5;
    localparam logic [ICODE_W-1:0] ICODE_OPQ    = 4'h6;
    localparam logic [ICODE_W-1:0] ICODE_JXX    = 4'h7;
    localparam logic [ICODE_W-1:0] ICODE_CALL   = 4'h8;
    localparam logic [ICODE_W-1:0] ICODE_RET    = 4'h9;
    localparam logic [ICODE_W-1:0] ICODE_PUSHQ  = 4'hA;
    localparam logic [ICODE_W-1:0] ICODE_POPQ   = 4'hB;

    localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
    localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
    localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
    localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEMORY    = 3'd4,
        S_WRITEBACK = 3'd5,
        S_PCUPD     = 3'd6,
        S_HALTED    = 3'd7
    } state_t;

    typedef struct packed {
        logic f;
        logic d;
        logic e;
        logic m;
        logic w;
    } stage_en_t;

    // Stage enable pattern for a given controller state (at most one bit set).
    function automatic stage_en_t stage_enables(input state_t s);
        stage_en_t en;
        en   = '0;
        en.f = (s == S_FETCH);
        en.d = (s == S_DECODE);
        en.e = (s == S_EXECUTE);
        en.m = (s == S_MEMORY);
        en.w = (s == S_WRITEBACK);
        return en;
    endfunction

    function automatic logic state_busy(input state_t s);
        return (s != S_IDLE) && (s != S_HALTED);
    endfunction

endpackage

// File: rtl/seq_next_pc.sv
// Next-PC selection from the latched icode and condition flag; purely
// combinational so the pipelined core can reuse it.
module seq_next_pc
    import y86_pkg::*;
(
    input  logic [ICODE_W-1:0] icode,
    input  logic               cnd,
    input  logic [ADDR_W-1:0]  val_c,
    input  logic [ADDR_W-1:0]  val_p,
    input  logic [ADDR_W-1:0]  val_m,
    output logic [ADDR_W-1:0]  next_pc_c
);

    always_comb begin
        next_pc_c = val_p;
        case (icode)
            ICODE_CALL: next_pc_c = val_c;
            ICODE_RET:  next_pc_c = val_m;
            ICODE_JXX:  next_pc_c = cnd ? val_c : val_p;
            default:    next_pc_c = val_p;
        endcase
    end

endmodule

// File: rtl/seq_stage_ctrl.sv
// Sequential Y86-64 stage controller: walks one instruction through the six
// stages, selects the next PC, counts retirements and traps on exceptions.
module seq_stage_ctrl
    import y86_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_PC = 64'd0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                run,
    input  logic                step,
    input  logic [ICODE_W-1:0]  icode,
    input  logic                imem_error,
    input  logic                invalid_instr,
    input  logic                dmem_error,
    input  logic                cnd,
    input  logic [ADDR_W-1:0]   valC,
    input  logic [ADDR_W-1:0]   valP,
    input  logic [ADDR_W-1:0]   valM,
    output logic [ADDR_W-1:0]   PC,
    output logic                en_f,
    output logic                en_d,
    output logic                en_e,
    output logic                en_m,
    output logic                en_w,
    output logic [STAT_W-1:0]   stat,
    output logic                busy,
    output logic [COUNT_W-1:0]  instr_count
);

    state_t              state;
    state_t              next_state;
    logic [STAT_W-1:0]   next_stat;
    stage_en_t           next_en;
    logic                next_busy;
    logic [ICODE_W-1:0]  icode_q;
    logic                cnd_q;
    logic [ADDR_W-1:0]   next_pc_c;

    seq_next_pc u_next_pc (
        .icode     (icode_q),
        .cnd       (cnd_q),
        .val_c     (valC),
        .val_p     (valP),
        .val_m     (valM),
        .next_pc_c (next_pc_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next state, exception status and the registered-output look-ahead.
    always_comb begin
        next_state = state;
        next_stat  = stat;
        case (state)
            S_IDLE: begin
                if (run || step) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (imem_error) begin
                    next_state = S_HALTED;
                    next_stat  = STAT_ADR;
                end else if (invalid_instr) begin
                    next_state = S_HALTED;
                    next_stat  = STAT_INS;
                end else if (icode == ICODE_HALT) begin
                    next_state = S_HALTED;
                    next_stat  = STAT_HLT;
                end else begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE:  next_state = S_EXECUTE;
            S_EXECUTE: next_state = S_MEMORY;
            S_MEMORY: begin
                if (dmem_error) begin
                    next_state = S_HALTED;
                    next_stat  = STAT_ADR;
                end else begin
                    next_state = S_WRITEBACK;
                end
            end
            S_WRITEBACK: next_state = S_PCUPD;
            S_PCUPD:     next_state = run ? S_FETCH : S_IDLE;
            S_HALTED:    next_state = S_HALTED;
            default:     next_state = S_IDLE;
        endcase
        next_en   = stage_enables(next_state);
        next_busy = state_busy(next_state);
    end

    // Enables and busy are registered one state ahead so they line up with state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_f <= 1'b0;
            en_d <= 1'b0;
            en_e <= 1'b0;
            en_m <= 1'b0;
            en_w <= 1'b0;
            busy <= 1'b0;
            stat <= STAT_AOK;
        end else begin
            en_f <= next_en.f;
            en_d <= next_en.d;
            en_e <= next_en.e;
            en_m <= next_en.m;
            en_w <= next_en.w;
            busy <= next_busy;
            stat <= next_stat;
        end
    end

    // Instruction context latches; cnd is frozen once EXECUTE ends.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            icode_q <= '0;
            cnd_q   <= 1'b0;
        end else begin
            if (state == S_FETCH) begin
                icode_q <= icode;
            end
            if (state == S_EXECUTE) begin
                cnd_q <= cnd;
            end
        end
    end

    // PC and retirement count only move when an instruction completes PCUPD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PC          <= RESET_PC;
            instr_count <= '0;
        end else if (state == S_PCUPD) begin
            PC          <= next_pc_c;
            instr_count <= instr_count + COUNT_W'(1);
        end
    end

endmodule

// File: tb/tb_seq_stage_ctrl.sv
// Directed self-checking bench for seq_stage_ctrl.
module tb_seq_stage_ctrl;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic        step;
    logic [3:0]  icode;
    logic        imem_error;
    logic        invalid_instr;
    logic        dmem_error;
    logic        cnd;
    logic [63:0] valC;
    logic [63:0] valP;
    logic [63:0] valM;
    logic [63:0] PC;
    logic        en_f, en_d, en_e, en_m, en_w;
    logic [2:0]  stat;
    logic        busy;
    logic [31:0] instr_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [4:0] ens;
    assign ens = {en_f, en_d, en_e, en_m, en_w};

    seq_stage_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .run           (run),
        .step          (step),
        .icode         (icode),
        .imem_error    (imem_error),
        .invalid_instr (invalid_instr),
        .dmem_error    (dmem_error),
        .cnd           (cnd),
        .valC          (valC),
        .valP          (valP),
        .valM          (valM),
        .PC            (PC),
        .en_f          (en_f),
        .en_d          (en_d),
        .en_e          (en_e),
        .en_m          (en_m),
        .en_w          (en_w),
        .stat          (stat),
        .busy          (busy),
        .instr_count   (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in FETCH; leaves it one cycle after PCUPD.
    task automatic do_instr(input string tag, input logic [3:0] ic, input logic c,
                            input logic [63:0] vc, input logic [63:0] vp, input logic [63:0] vm);
        icode = ic; valC = vc; valP = vp; valM = vm;
        chk({tag, ".fetch"}, 64'(ens), 64'b10000);
        tick();
        chk({tag, ".decode"}, 64'(ens), 64'b01000);
        cnd = c;
        tick();
        chk({tag, ".execute"}, 64'(ens), 64'b00100);
        tick();
        cnd = ~c;
        chk({tag, ".memory"}, 64'(ens), 64'b00010);
        tick();
        chk({tag, ".writeback"}, 64'(ens), 64'b00001);
        tick();
        chk({tag, ".pcupd_ens"}, 64'(ens), 64'b00000);
        chk({tag, ".pcupd_busy"}, 64'(busy), 64'd1);
        tick();
        cnd = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; step = 1'b0; icode = 4'h0;
        imem_error = 1'b0; invalid_instr = 1'b0; dmem_error = 1'b0; cnd = 1'b0;
        valC = 64'd0; valP = 64'd0; valM = 64'd0;
        #12;
        chk("rst.pc", PC, 64'd0);
        chk("rst.stat", 64'(stat), 64'd1);
        chk("rst.count", 64'(instr_count), 64'd0);
        chk("rst.ens", 64'(ens), 64'd0);
        chk("rst.busy", 64'(busy), 64'd0);

        // Free-run: nop then irmovq
        rst_n = 1'b1; run = 1'b1;
        tick();
        do_instr("nop", 4'h1, 1'b0, 64'h0, 64'd2, 64'h0);
        chk("nop.pc", PC, 64'd2);
        do_instr("irmovq", 4'h3, 1'b0, 64'h0, 64'd12, 64'h0);
        chk("irmovq.pc", PC, 64'd12);
        chk("irmovq.count", 64'(instr_count), 64'd2);

        // Conditional jumps, cnd later toggled after EXECUTE
        do_instr("jxx_t", 4'h7, 1'b1, 64'h40, 64'h09, 64'h0);
        chk("jxx_t.pc", PC, 64'h40);
        do_instr("jxx_nt", 4'h7, 1'b0, 64'h40, 64'h09, 64'h0);
        chk("jxx_nt.pc", PC, 64'h09);

        // call/ret; run drops before ret completes
        do_instr("call", 4'h8, 1'b0, 64'h100, 64'h0A, 64'h77);
        chk("call.pc", PC, 64'h100);
        run = 1'b0;
        do_instr("ret", 4'h9, 1'b0, 64'h55, 64'h66, 64'h13);
        chk("ret.pc", PC, 64'h13);
        chk("ret.count", 64'(instr_count), 64'd6);
        chk("ret.idle_ens", 64'(ens), 64'd0);
        chk("ret.idle_busy", 64'(busy), 64'd0);
        tick(); tick();
        chk("idle_hold.busy", 64'(busy), 64'd0);

        // Single step
        step = 1'b1;
        tick();
        step = 1'b0;
        do_instr("step", 4'h6, 1'b0, 64'h0, 64'h20, 64'h0);
        chk("step.pc", PC, 64'h20);
        chk("step.count", 64'(instr_count), 64'd7);
        chk("step.busy", 64'(busy), 64'd0);
        tick();
        chk("step.stays_idle", 64'(ens), 64'd0);

        // Step with data memory fault
        step = 1'b1;
        tick();
        step = 1'b0;
        icode = 4'h4; valP = 64'h30;
        chk("dmem.fetch", 64'(ens), 64'b10000);
        tick(); tick(); tick();
        chk("dmem.memory", 64'(ens), 64'b00010);
        dmem_error = 1'b1;
        tick();
        dmem_error = 1'b0;
        chk("dmem.ens", 64'(ens), 64'd0);
        chk("dmem.stat", 64'(stat), 64'd3);
        chk("dmem.busy", 64'(busy), 64'd0);
        chk("dmem.pc", PC, 64'h20);
        chk("dmem.count", 64'(instr_count), 64'd7);
        step = 1'b1; run = 1'b1;
        tick();
        step = 1'b0;
        tick(); tick();
        chk("dmem.no_en_w", 64'(ens), 64'd0);
        chk("dmem.halt_hold", 64'(stat), 64'd3);
        chk("dmem.halt_pc", PC, 64'h20);

        // Reset mid-instruction
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        run = 1'b1;
        tick();
        do_instr("pre", 4'h1, 1'b0, 64'h0, 64'h2, 64'h0);
        chk("pre.pc", PC, 64'h2);
        icode = 4'h1; valP = 64'h4;
        tick(); tick();
        chk("mid.execute", 64'(ens), 64'b00100);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.ens", 64'(ens), 64'd0);
        chk("mid_rst.pc", PC, 64'd0);
        chk("mid_rst.count", 64'(instr_count), 64'd0);
        chk("mid_rst.stat", 64'(stat), 64'd1);
        chk("mid_rst.busy", 64'(busy), 64'd0);
        run = 1'b0;
        #2;
        rst_n = 1'b1;
        tick(); tick();
        chk("post_rst.idle", 64'(ens), 64'd0);

        // Fetch fault: imem_error wins over invalid_instr
        run = 1'b1;
        tick();
        chk("imem.fetch", 64'(ens), 64'b10000);
        icode = 4'h1; imem_error = 1'b1; invalid_instr = 1'b1;
        tick();
        imem_error = 1'b0; invalid_instr = 1'b0;
        chk("imem.stat", 64'(stat), 64'd3);
        chk("imem.ens", 64'(ens), 64'd0);
        chk("imem.pc", PC, 64'd0);
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        chk("imem.step_ignored", 64'(ens), 64'd0);
        chk("imem.busy", 64'(busy), 64'd0);

        // invalid_instr alone -> INS
        rst_n = 1'b0; #1; rst_n = 1'b1;
        tick();
        invalid_instr = 1'b1; icode = 4'h1;
        tick();
        invalid_instr = 1'b0;
        chk("ins.stat", 64'(stat), 64'd4);

        // halt icode -> HLT
        rst_n = 1'b0; #1; rst_n = 1'b1;
        tick();
        icode = 4'h0;
        tick();
        chk("hlt.stat", 64'(stat), 64'd2);
        chk("hlt.count", 64'(instr_count), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
